score_bcd_controller: RTL and testbench

Owns the game score register and sequences its conversion to display digits. Arbitrates point-award requests from several game-logic sources using round-robin, and adds the awarded points with saturation. Runs a multi-cycle shift-add-3 binary-to-BCD conversion and presents three stable BCD digits, with a valid flag, to the seven-segment decoders.

---
 rtl/score_bcd_controller_if.sv | 28 ++
 rtl/score_bcd_controller.sv | 126 ++++++++++++
 tb/tb_score_bcd_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/score_bcd_controller_if.sv
// Award/score bus between game logic and the score controller.
// The master side raises requests and clear; the slave side returns grants, score and digits.
interface score_bcd_controller_if #(
    parameter int N_REQ   = 4,
    parameter int PTS_W   = 4,
    parameter int SCORE_W = 10
);
    logic [N_REQ-1:0]       req;
    logic [N_REQ*PTS_W-1:0] pts;
    logic                   clear;
    logic [N_REQ-1:0]       gnt;
    logic [SCORE_W-1:0]     score;
    logic [3:0]             dig_2;
    logic [3:0]             dig_1;
    logic [3:0]             dig_0;
    logic                   busy;
    logic                   valid;

    modport master (
        output req, pts, clear,
        input  gnt, score, dig_2, dig_1, dig_0, busy, valid
    );

    modport slave (
        input  req, pts, clear,
        output gnt, score, dig_2, dig_1, dig_0, busy, valid
    );
endinterface

// File: rtl/score_bcd_controller.sv
// Saturating score register with round-robin award arbitration and a
// multi-cycle shift-add-3 converter feeding three stable BCD digits.
module score_bcd_controller #(
    parameter int N_REQ     = 4,
    parameter int PTS_W     = 4,
    parameter int SCORE_W   = 10,
    parameter int SCORE_MAX = 999
) (
    input  logic                 clk,
    input  logic                 resetn,
    score_bcd_controller_if.slave bus
);
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(SCORE_W + 1);

    typedef enum logic {IDLE, CONV} state_t;

    state_t             r_state;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] r_bin;
    logic [11:0]        r_bcd;
    logic [11:0]        r_dig;
    logic [PTR_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_clear_pend;
    logic               r_valid;
    logic               r_busy;

    logic               w_any;
    logic [PTR_W-1:0]   w_sel;
    logic               w_award;
    logic [N_REQ-1:0]   w_gnt;
    logic [PTS_W-1:0]   w_pts;
    logic [SCORE_W:0]   w_sum;
    logic [SCORE_W-1:0] w_new_score;
    logic [11:0]        w_adj;
    logic [11:0]        w_bcd_nxt;
    logic               w_unused_msb;

    // First requester at or after the pointer, wrapping.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_any && bus.req[(int'(r_ptr) + k) % N_REQ]) begin
                w_any = 1'b1;
                w_sel = PTR_W'((int'(r_ptr) + k) % N_REQ);
            end
        end
    end

    assign w_award     = resetn && (r_state == IDLE) && !bus.clear && !r_clear_pend && w_any;
    assign w_gnt       = w_award ? (N_REQ'(1) << w_sel) : '0;
    assign w_pts       = bus.pts[w_sel*PTS_W +: PTS_W];
    assign w_sum       = {1'b0, r_score} + (SCORE_W+1)'(w_pts);
    assign w_new_score = (w_sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX)
                                                           : w_sum[SCORE_W-1:0];

    always_comb begin
        w_adj = r_bcd;
        for (int n = 0; n < 3; n++) begin
            if (r_bcd[n*4 +: 4] >= 4'd5) w_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
        end
    end

    // Scores never exceed 999, so the top adjusted bit always shifts out as 0.
    assign w_bcd_nxt    = {w_adj[10:0], r_bin[SCORE_W-1]};
    assign w_unused_msb = w_adj[11];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= IDLE;
            r_score      <= '0;
            r_bin        <= '0;
            r_bcd        <= '0;
            r_dig        <= '0;
            r_ptr        <= '0;
            r_cnt        <= '0;
            r_clear_pend <= 1'b0;
            r_valid      <= 1'b1;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.clear || r_clear_pend) begin
                        r_score      <= '0;
                        r_dig        <= '0;
                        r_valid      <= 1'b1;
                        r_clear_pend <= 1'b0;
                    end else if (w_award) begin
                        r_score <= w_new_score;
                        r_ptr   <= PTR_W'((int'(w_sel) + 1) % N_REQ);
                        r_bin   <= w_new_score;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    if (bus.clear) r_clear_pend <= 1'b1;
                    r_bcd <= w_bcd_nxt;
                    r_bin <= {r_bin[SCORE_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    // Digits only change here, so intermediate values never reach the display.
                    if (r_cnt == CNT_W'(SCORE_W - 1)) begin
                        r_dig   <= w_bcd_nxt;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = w_gnt;
    assign bus.score = r_score;
    assign bus.dig_2 = r_dig[11:8];
    assign bus.dig_1 = r_dig[7:4];
    assign bus.dig_0 = r_dig[3:0];
    assign bus.busy  = r_busy;
    assign bus.valid = r_valid;
endmodule

// File: tb/tb_score_bcd_controller.sv
// Directed bench for score_bcd_controller: awards, saturation, round-robin order,
// deferred clear and reset abort, checked against hand-derived values.
module tb_score_bcd_controller;
    logic clk = 1'b0;
    logic resetn;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   m_score = 0;

    score_bcd_controller_if ifc ();

    score_bcd_controller dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        ifc.req   = '0;
        ifc.clear = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        m_score = 0;
    endtask

    // One award on requester idx from IDLE; checks grant, latency and digits.
    task automatic award(input int idx, input int p);
        int b;
        int exp;
        exp = (m_score + p > 999) ? 999 : m_score + p;
        ifc.pts[idx*4 +: 4] = p[3:0];
        ifc.req = 4'(1 << idx);
        #1;
        chk("aw_gnt", ifc.gnt, 1 << idx);
        tick();
        ifc.req = '0;
        chk("aw_score", ifc.score, exp);
        b = 0;
        repeat (10) begin
            if (ifc.busy && !ifc.valid) b++;
            tick();
        end
        chk("aw_busy_cycles", b, 10);
        chk("aw_valid", ifc.valid, 1);
        chk("aw_busy_end", ifc.busy, 0);
        chk("aw_digits", ifc.dig_2*100 + ifc.dig_1*10 + ifc.dig_0, exp);
        m_score = exp;
    endtask

    initial begin
        ifc.pts = '0;
        do_reset();

        // Reset / idle state
        repeat (5) tick();
        chk("rst_score", ifc.score, 0);
        chk("rst_digits", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 0);
        chk("rst_valid", ifc.valid, 1);
        chk("rst_busy", ifc.busy, 0);
        chk("rst_gnt", ifc.gnt, 0);

        // First award of 7 -> 0/0/7
        award(0, 7);
        chk("d7_dig0", ifc.dig_0, 7);
        chk("d7_dig1", ifc.dig_1, 0);

        // Preload to 995, then saturate at 999
        repeat (65) award(0, 15);
        award(0, 13);
        chk("pre_995", ifc.score, 995);
        award(2, 9);
        chk("sat_score", ifc.score, 999);
        chk("sat_digits", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 12'h999);
        award(3, 5);
        chk("sat_hold", ifc.score, 999);

        // Round-robin order with all requesters held, pts=1
        do_reset();
        ifc.pts = 16'h1111;
        ifc.req = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("rr_gnt", ifc.gnt, 1 << (k % 4));
            tick();
            if (k == 4) ifc.req = '0;
            chk("rr_gnt_pulse", ifc.gnt, 0);
            repeat (10) tick();
        end
        chk("rr_score", ifc.score, 5);
        chk("rr_digits", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 12'h005);
        chk("rr_valid", ifc.valid, 1);

        // Clear in IDLE, then clear deferred during a conversion
        ifc.clear = 1'b1;
        #1;
        chk("clr_idle_gnt", ifc.gnt, 0);
        tick();
        ifc.clear = 1'b0;
        chk("clr_idle_score", ifc.score, 0);
        chk("clr_idle_valid", ifc.valid, 1);
        m_score = 0;
        ifc.pts = 16'h0C00 | 16'h00C0;
        ifc.req = 4'b0010;
        #1;
        chk("clr_aw_gnt", ifc.gnt, 4'b0010);
        tick();
        ifc.req = '0;
        repeat (2) tick();
        ifc.clear = 1'b1;
        ifc.pts   = 16'h04C0;
        ifc.req   = 4'b0100;
        tick();
        ifc.clear = 1'b0;
        begin
            int g = 0;
            repeat (7) begin
                if (ifc.gnt != 0) g++;
                tick();
            end
            chk("clr_no_gnt_conv", g, 0);
        end
        chk("clr_conv_digits", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 12'h012);
        chk("clr_conv_valid", ifc.valid, 1);
        chk("clr_pend_gnt", ifc.gnt, 0);
        tick();
        chk("clr_score", ifc.score, 0);
        chk("clr_digits", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 0);
        chk("clr_after_gnt", ifc.gnt, 4'b0100);
        tick();
        ifc.req = '0;
        chk("clr_next_score", ifc.score, 4);
        repeat (10) tick();
        chk("clr_next_digits", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 12'h004);

        // Reset mid-conversion of 250
        do_reset();
        ifc.pts = '0;
        repeat (16) award(0, 15);
        ifc.pts = 16'h000A;
        ifc.req = 4'b0001;
        #1;
        chk("ab_gnt", ifc.gnt, 1);
        tick();
        ifc.req = '0;
        chk("ab_score", ifc.score, 250);
        repeat (3) tick();
        resetn  = 1'b0;
        ifc.req = 4'b1111;
        #1;
        chk("ab_score_rst", ifc.score, 0);
        chk("ab_digits_rst", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 0);
        chk("ab_valid_rst", ifc.valid, 1);
        chk("ab_busy_rst", ifc.busy, 0);
        chk("ab_gnt_rst", ifc.gnt, 0);
        tick();
        chk("ab_gnt_rst2", ifc.gnt, 0);
        tick();
        ifc.req = '0;
        resetn  = 1'b1;
        m_score = 0;
        tick();
        award(0, 3);
        chk("ab_digits_3", {ifc.dig_2, ifc.dig_1, ifc.dig_0}, 12'h003);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
